ps2_key_fifo_module: RTL
========================

# ps2_key_fifo_module

Consumer of the PS/2 byte decoder's output (`PS2_Data`, `PS2_Done_Sig`), sitting between the decoder and application logic. It classifies each received set-2 byte and tracks the E0 extended prefix and Caps Lock state. It translates make codes to ASCII and buffers key events in a FIFO read through a valid/read handshake. The application never has to catch the decoder's one-cycle done pulse.

## Interface
- `DEPTH`, 8: FIFO entries, power of two, 2..64.
- `AW`, 3: log2(`DEPTH`).

- `CLK`  in  1  system clock.
- `RSTn`  in  1  asynchronous active-low reset.
- `PS2_Data`  in  8  byte from decoder; valid in the cycle `PS2_Done_Sig`=1.
- `PS2_Done_Sig`  in  1  one-cycle pulse, byte available.
- `Key_Read`  in  1  pop request; effective only when `Key_Valid`=1.
- `Key_Valid`  out  1  FIFO non-empty.
- `Key_Code`  out  8  head entry scan code.
- `Key_Ext`  out  1  head entry was E0-prefixed.
- `Key_ASCII`  out  8  head entry ASCII, 0x00 if unmapped.
- `Key_Count`  out  AW+1  entries held, 0..DEPTH.
- `Caps_State`  out  1  current Caps Lock state.
- `Overflow_Sig`  out  1  sticky; an event was dropped on full.

## Operation
- Reset: FIFO empty, `Key_Count`=0, `Key_Valid`=0, `Key_Code`/`Key_ASCII`=0x00, `Key_Ext`=0, `Caps_State`=0, `Overflow_Sig`=0, ext/break flags cleared, capture stage invalid.
- Byte classification on `PS2_Done_Sig`=1:
  - 0xE0: set ext flag. No push.
  - 0xF0: set break flag. No push. Robustness only; the decoder normally swallows break sequences.
  - 0xE1: ignored. No push. Flags unchanged.
  - 0x00, 0xAA, 0xEE, 0xFA, 0xFC, 0xFD, 0xFE, 0xFF (device responses): discarded. Clear both flags.
  - Any other byte with break flag set: discarded. Clear both flags.
  - Any other byte: make event. Load capture stage with {ext flag, byte, ASCII}, then clear both flags.
- Caps Lock: non-extended make 0x58 toggles `Caps_State` in the capture cycle. The event is still pushed, with ASCII 0x00.
- ASCII map, non-extended, set 2:
  - Letters A–Z: 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A. Output 0x61+i when `Caps_State`=0, 0x41+i when 1. Uses caps state before any toggle in the same cycle.
  - Digits 0–9: 45 16 1E 26 25 2E 36 3D 3E 46 → 0x30..0x39.
  - Space 29→0x20, Enter 5A→0x0D, Backspace 66→0x08, Tab 0D→0x09, Esc 76→0x1B.
  - Extended: E0 5A→0x0D.
  - Everything else → 0x00.
- FIFO:
  - Write when the capture stage is valid.
  - Full with no simultaneous pop: entry dropped, `Overflow_Sig`←1, held until reset.
  - Full with a pop in the same cycle: write accepted, count stays `DEPTH`.
  - Pop and write in the same cycle at count 0: impossible (the pop needs `Key_Valid`=1).
  - Pop and write in the same cycle at any count 1..DEPTH: count unchanged.
  - Pointers wrap modulo `DEPTH`.
  - Head outputs are registered or RAM-read combinationally from the head pointer. They are stable while `Key_Valid`=1 and no pop occurs.
- `Key_Read` while `Key_Valid`=0: no effect.

## Timing
- Done pulse in cycle t → capture stage valid in t+1 → FIFO written at end of t+1 → `Key_Valid`=1, head outputs valid in t+2 (empty FIFO).
- Pop: `Key_Read`=1 with `Key_Valid`=1 in cycle t → next entry, or `Key_Valid`=0, in t+1.
- `Caps_State` updates in t+1 after the 0x58 done pulse.
- Back-to-back done pulses in consecutive cycles are each processed. Sustained input rate is one byte per cycle.
- Reset asserted mid-stream: all state cleared immediately. A pending ext flag and capture are lost.

## Test plan
- Reset, then bytes 0x1C, 0x32 with pulses 20 cycles apart, no reads → `Key_Count`=2. Head `Key_Code`=0x1C, `Key_ASCII`=0x61, `Key_Ext`=0. After one pop → 0x32/0x62. After second pop → `Key_Valid`=0.
- Bytes 0x58, 0x1C → entries {0x58, 0x00} and {0x1C, 0x41}, `Caps_State`=1. A further 0x58 → `Caps_State`=0.
- Bytes 0xE0, 0x75 → single entry, `Key_Ext`=1, `Key_Code`=0x75, `Key_ASCII`=0x00. Bytes 0xE0, 0x5A → `Key_ASCII`=0x0D.
- Bytes 0xAA, 0xFA, 0xF0, 0x1C, then 0x29 → only one entry {0x29, 0x20}.
- 9 make codes with no reads (`DEPTH`=8) → `Key_Count`=8, `Overflow_Sig`=1, first 8 retained in order. Then a pop coincident with a write while full → count stays 8, new entry at tail.
- Pulse 0xE0, then assert `RSTn`=0 for 2 cycles, then 0x75 → entry `Key_Ext`=0; all outputs at reset values during reset.

Source files
------------

// File: rtl/ps2_key_fifo_module.sv
// PS/2 set-2 key event classifier, ASCII translator and event FIFO.
// Tracks the E0 prefix and Caps Lock; head entry is read through Key_Valid/Key_Read.
module ps2_key_fifo_module #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic [7:0]    PS2_Data,
    input  logic          PS2_Done_Sig,
    input  logic          Key_Read,
    output logic          Key_Valid,
    output logic [7:0]    Key_Code,
    output logic          Key_Ext,
    output logic [7:0]    Key_ASCII,
    output logic [AW:0]   Key_Count,
    output logic          Caps_State,
    output logic          Overflow_Sig
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic          ext_q, ext_d;
    logic          brk_q, brk_d;
    logic          caps_q, caps_d;
    logic          load;
    logic          cap_valid;
    logic          cap_ext;
    logic [7:0]    cap_code;
    logic [7:0]    cap_ascii;

    logic [7:0]    mem_code  [DEPTH];
    logic [7:0]    mem_ascii [DEPTH];
    logic          mem_ext   [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          ovf_q;
    logic          pop;
    logic          full;
    logic          wr_en;

    function automatic logic [7:0] ascii_of(
        input logic [7:0] code,
        input logic       ext,
        input logic       caps
    );
        logic [7:0] l;
        logic [7:0] o;
        l = 8'h00;
        o = 8'h00;
        if (ext) begin
            if (code == 8'h5A) o = 8'h0D;
        end else begin
            case (code)
                8'h1C: l = 8'h61;
                8'h32: l = 8'h62;
                8'h21: l = 8'h63;
                8'h23: l = 8'h64;
                8'h24: l = 8'h65;
                8'h2B: l = 8'h66;
                8'h34: l = 8'h67;
                8'h33: l = 8'h68;
                8'h43: l = 8'h69;
                8'h3B: l = 8'h6A;
                8'h42: l = 8'h6B;
                8'h4B: l = 8'h6C;
                8'h3A: l = 8'h6D;
                8'h31: l = 8'h6E;
                8'h44: l = 8'h6F;
                8'h4D: l = 8'h70;
                8'h15: l = 8'h71;
                8'h2D: l = 8'h72;
                8'h1B: l = 8'h73;
                8'h2C: l = 8'h74;
                8'h3C: l = 8'h75;
                8'h2A: l = 8'h76;
                8'h1D: l = 8'h77;
                8'h22: l = 8'h78;
                8'h35: l = 8'h79;
                8'h1A: l = 8'h7A;
                8'h45: o = 8'h30;
                8'h16: o = 8'h31;
                8'h1E: o = 8'h32;
                8'h26: o = 8'h33;
                8'h25: o = 8'h34;
                8'h2E: o = 8'h35;
                8'h36: o = 8'h36;
                8'h3D: o = 8'h37;
                8'h3E: o = 8'h38;
                8'h46: o = 8'h39;
                8'h29: o = 8'h20;
                8'h5A: o = 8'h0D;
                8'h66: o = 8'h08;
                8'h0D: o = 8'h09;
                8'h76: o = 8'h1B;
                default: o = 8'h00;
            endcase
            if (l != 8'h00) o = caps ? (l - 8'h20) : l;
        end
        return o;
    endfunction

    always_comb begin
        ext_d  = ext_q;
        brk_d  = brk_q;
        caps_d = caps_q;
        load   = 1'b0;
        if (PS2_Done_Sig) begin
            case (PS2_Data)
                8'hE0: ext_d = 1'b1;
                8'hF0: brk_d = 1'b1;
                8'hE1: ;
                8'h00, 8'hAA, 8'hEE, 8'hFA,
                8'hFC, 8'hFD, 8'hFE, 8'hFF: begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
                default: begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                    if (!brk_q) begin
                        load = 1'b1;
                        if (!ext_q && PS2_Data == 8'h58)
                            caps_d = ~caps_q;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            caps_q    <= 1'b0;
            cap_valid <= 1'b0;
            cap_ext   <= 1'b0;
            cap_code  <= 8'h00;
            cap_ascii <= 8'h00;
        end else begin
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            caps_q    <= caps_d;
            cap_valid <= load;
            if (load) begin
                cap_ext   <= ext_q;
                cap_code  <= PS2_Data;
                cap_ascii <= ascii_of(PS2_Data, ext_q, caps_q);
            end
        end
    end

    // A pop frees the head slot, so a full FIFO can still accept a write.
    assign full  = (count == FULL_CNT);
    assign pop   = Key_Read && (count != '0);
    assign wr_en = cap_valid && (!full || pop);

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_code[wr_ptr]  <= cap_code;
            mem_ascii[wr_ptr] <= cap_ascii;
            mem_ext[wr_ptr]   <= cap_ext;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !pop)      count <= count + 1'b1;
            else if (pop && !wr_en) count <= count - 1'b1;
            if (cap_valid && full && !pop) ovf_q <= 1'b1;
        end
    end

    assign Key_Valid    = (count != '0);
    assign Key_Code     = Key_Valid ? mem_code[rd_ptr]  : 8'h00;
    assign Key_ASCII    = Key_Valid ? mem_ascii[rd_ptr] : 8'h00;
    assign Key_Ext      = Key_Valid ? mem_ext[rd_ptr]   : 1'b0;
    assign Key_Count    = count;
    assign Caps_State   = caps_q;
    assign Overflow_Sig = ovf_q;

endmodule
